// File: rtl/melody_sequencer_pkg.sv
// Shared types and constants for the melody beat scheduler.
package melody_pkg;

  localparam int unsigned BEAT_W = 8;
  localparam int unsigned TICK_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [1:0] TEMPO_X1    = 2'd0;
  localparam logic [1:0] TEMPO_SLOW2 = 2'd1;
  localparam logic [1:0] TEMPO_FAST2 = 2'd2;
  localparam logic [1:0] TEMPO_SLOW4 = 2'd3;

  // Cycles per beat for a tempo selection; the fast setting floors odd bases.
  function automatic logic [TICK_W-1:0] tempo_div(input logic [1:0] sel,
                                                  input logic [TICK_W-1:0] base);
    logic [TICK_W-1:0] d;
    case (sel)
      TEMPO_SLOW2: d = base << 1;
      TEMPO_FAST2: d = base >> 1;
      TEMPO_SLOW4: d = base << 2;
      default:     d = base;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/melody_sequencer_beat_tick_gen.sv
// Beat tick generator: counts cycles within a beat against a latched divisor
// and flags the last cycle of the beat. The divisor is reloaded only on clear
// or at a beat boundary so a tempo change never shortens the running beat.
module beat_tick_gen
  import melody_pkg::*;
#(
  parameter int unsigned BEAT_DIV = 6_250_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  input  logic              clear_i,
  input  logic [1:0]        tempo_sel_i,
  output logic [TICK_W-1:0] tick_o,
  output logic [TICK_W-1:0] div_o,
  output logic              boundary_o
);

  localparam logic [TICK_W-1:0] BASE = TICK_W'(BEAT_DIV);
  localparam logic [TICK_W-1:0] ONE  = TICK_W'(1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TICK_W-1:0] div_q, div_d;

  assign boundary_o = run_i && (tick_q == (div_q - ONE));
  assign tick_o     = tick_q;
  assign div_o      = div_q;

  // Next tick / divisor: clear and boundary both restart the beat with a fresh tempo.
  always_comb begin
    tick_d = tick_q;
    div_d  = div_q;
    if (clear_i || boundary_o) begin
      tick_d = '0;
      div_d  = tempo_div(tempo_sel_i, BASE);
    end else if (run_i) begin
      tick_d = tick_q + ONE;
    end
  end

  // Tick and divisor registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q <= '0;
      div_q  <= BASE;
    end else begin
      tick_q <= tick_d;
      div_q  <= div_d;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody beat scheduler: steps an 8-bit beat index at a programmable tempo
// with play/pause/stop control, end-of-song pulse and an articulating note gate.
// Build option: define MELODY_LOOP_EN to wrap back to beat 0 and keep playing
// at the end of the song; by default the sequencer returns to IDLE.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | stopped; beat index and tick held at 0, tempo tracked
// ST_PLAY  | ticking; beat index advances at each beat boundary
// ST_PAUSE | tick and beat index frozen, gate muted, awaiting start
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned BEAT_DIV  = 6_250_000,
  parameter int unsigned GAP_TICKS = 312_500,
  parameter int unsigned SONG_LEN  = 68
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        tempo_sel,
  output logic [BEAT_W-1:0] beats,
  output logic              note_gate,
  output logic              beat_stb,
  output logic              playing,
  output logic              done
);

`ifdef MELODY_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SONG_LEN - 1);
  localparam logic [TICK_W-1:0] GAP_T     = TICK_W'(GAP_TICKS);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beats_q;
  logic              beat_stb_q, done_q;
  logic [TICK_W-1:0] tick, div;
  logic              boundary, song_end;
  logic              run, clear, play_s, gate_s;

  beat_tick_gen #(.BEAT_DIV(BEAT_DIV)) u_tick (
    .clk_i       (CLOCK_50),
    .rst_ni      (rst_n),
    .run_i       (run),
    .clear_i     (clear),
    .tempo_sel_i (tempo_sel),
    .tick_o      (tick),
    .div_o       (div),
    .boundary_o  (boundary)
  );

  assign song_end = boundary && (beats_q == LAST_BEAT);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; stop outranks start, start outranks pause.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!stop && start) state_d = ST_PLAY;
      ST_PLAY: begin
        if (stop)                      state_d = ST_IDLE;
        else if (song_end && !LOOP_EN) state_d = ST_IDLE;
        else if (!start && pause)      state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_PLAY;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; a stop this cycle freezes the tick so no boundary can fire.
  always_comb begin
    play_s = (state_q == ST_PLAY);
    gate_s = play_s && (tick < (div - GAP_T));
    run    = play_s && !stop;
    clear  = (state_q == ST_IDLE) || stop;
  end

  // Beat index and registered strobes.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      beats_q    <= '0;
      beat_stb_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      beat_stb_q <= boundary;
      done_q     <= song_end;
      if (clear || song_end) beats_q <= '0;
      else if (boundary)     beats_q <= beats_q + BEAT_W'(1);
    end
  end

  assign beats     = beats_q;
  assign beat_stb  = beat_stb_q;
  assign done      = done_q;
  assign playing   = play_s;
  assign note_gate = gate_s;

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Beat scheduler that drives the 8-bit `beats` index into a melody player (the note lookup ROM fed by the notegen tone bank). It steps the index at a programmable tempo and provides play/pause/stop control, end-of-song detection and a note gate. The gate inserts a short silence between consecutive beats so that repeated notes are articulated. The block sits between the board's control inputs and one or more melody players that share a single beat index.

## Interface
Parameters:
- `BEAT_DIV`, 6_250_000: `CLOCK_50` cycles per beat at tempo_sel=0 (8 beats/s).
- `GAP_TICKS`, 312_500: cycles at the end of each beat with `note_gate` low. Must be < `BEAT_DIV`/2.
- `SONG_LEN`, 68: number of beats. `beats` runs 0..SONG_LEN-1. Must be ≤ 256.

Ports:
- `CLOCK_50`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: begin from IDLE, or resume from PAUSE.
- `stop`  in  1  one-cycle pulse: abort to IDLE.
- `pause`  in  1  one-cycle pulse: PLAY→PAUSE.
- `tempo_sel`  in  2  tempo select: 0=×1, 1=×2 slower, 2=×2 faster, 3=×4 slower.
- `beats`  out  8  beat index to the player(s).
- `note_gate`  out  1  high while the current note should sound.
- `beat_stb`  out  1  one-cycle pulse on each beat advance.
- `playing`  out  1  high in PLAY.
- `done`  out  1  one-cycle pulse when the last beat expires.

## Operation
- States: IDLE, PLAY, PAUSE.
- Command priority: stop > start > pause.
- IDLE:
  - beats=0, tick=0, note_gate=0.
  - start → PLAY on the next edge, with tick=0 and tempo_sel latched into `div`.
- PLAY:
  - tick counts 0..div-1.
  - At tick==div-1: tick←0, beat_stb=1 for that cycle, beats←beats+1.
  - tempo_sel is re-latched only at this boundary. A change takes effect on the next beat and never truncates the current beat.
- End of song: tick==div-1 with beats==SONG_LEN-1. The behaviour depends on the loop macro (see Configuration). done=1 for that cycle.
- PAUSE:
  - tick and beats hold; note_gate=0.
  - start → PLAY, continuing from the held tick.
  - pause while already in PAUSE is ignored.
- stop in any state → IDLE, beats=0, tick=0. No done pulse.
- start while in PLAY is ignored. pause in IDLE is ignored.
- div values: BEAT_DIV, 2·BEAT_DIV, BEAT_DIV/2 (floor), 4·BEAT_DIV.
  - tick is 32 bits.
  - No arithmetic wraps for legal parameters.
- note_gate = (state==PLAY) && (tick < div-GAP_TICKS).
  - For div=BEAT_DIV/2 the gap stays GAP_TICKS cycles long.
- The player maps index 0 to a rest, so IDLE is silent. note_gate additionally mutes.

## Timing
- All outputs are registered except note_gate and playing, which are decoded combinationally from registered state and tick.
- Reset values: beats=0, note_gate=0, beat_stb=0, playing=0, done=0, state=IDLE, tick=0.
- Latency:
  - start pulse at edge N → playing=1 after edge N+1.
  - First beat_stb follows div cycles later.
  - Beat 0 lasts exactly div cycles.
- stop is effective at the next edge, mid-beat or otherwise.
- Reset mid-song is asynchronous: it clears everything immediately, and no done pulse is issued.
- stop coincident with the final tick: stop wins, done=0.
- pause coincident with a tick boundary: the beat advance completes (beats increments, beat_stb=1), then state=PAUSE with tick=0.

## Configuration
- `MELODY_LOOP_EN` defined:
  - At end of song, beats←0, tick←0 and the state stays PLAY. done pulses on every wrap.
  - beat_stb is asserted on the wrap.
- `MELODY_LOOP_EN` undefined:
  - At end of song, the state goes to IDLE with beats=0 and done pulses once.
  - beat_stb is asserted on the final expiry; playing falls the next cycle.

## Structure
- Package `melody_pkg`:
  - State enum (IDLE, PLAY, PAUSE).
  - tempo_sel encodings as named constants.
  - Beat-index width constant (8).
- Sub-module `beat_tick_gen`: holds the tick counter and the div latch, and produces the boundary pulse.
  - Inputs: run, clear, tempo_sel.
  - Outputs: tick value, boundary.
  - The FSM and beat counter stay in the top module.

## Test plan
All scenarios use BEAT_DIV=8, GAP_TICKS=2, SONG_LEN=4.
- **Reset and start:**
  - After reset, all outputs are 0.
  - start pulse → playing=1 next cycle.
  - beat_stb every 8 cycles; beats steps 0,1,2,3.
  - note_gate high 6 cycles, low 2 cycles per beat.
- **End of song, loop undefined:** after 4 beats (32 cycles), done=1 for one cycle, then playing=0 and beats=0.
- **End of song, `MELODY_LOOP_EN` defined:** beats goes 3→0, playing stays 1, done pulses every 32 cycles.
- **Pause/resume:**
  - pause at tick 3 of beat 1 → beats=1 and tick hold for 20 cycles, note_gate=0.
  - start → beat 1 ends 5 cycles later.
- **Tempo change:**
  - tempo_sel changed 0→1 mid-beat 0: beat 0 remains 8 cycles, beat 1 lasts 16 cycles.
  - tempo_sel=2: beats last 4 cycles, note_gate high 2.
- **Simultaneous events:**
  - start+stop together → remains IDLE.
  - stop on the final tick → done=0, beats=0.
  - rst_n low mid-beat 2 → outputs clear asynchronously.
